// File: rtl/spi_aes_frame_pkg.sv
// spi_aes_pkg: shared state encoding, widths and key-length helpers for the
// serial AES framing controller.
package spi_aes_pkg;

  localparam int AES_BLOCK_W = 128;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam int KEY_W_128 = 128;
  localparam int KEY_W_192 = 192;
  localparam int KEY_W_256 = 256;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_DATA = 3'd1,
    LOAD_KEY  = 3'd2,
    START     = 3'd3,
    WAIT_CORE = 3'd4,
    SHIFT_OUT = 3'd5
  } state_e;

  function automatic logic key_w_legal(input int w);
    return (w == KEY_W_128) || (w == KEY_W_192) || (w == KEY_W_256);
  endfunction

endpackage

// File: rtl/spi_aes_frame_shreg.sv
// spi_aes_shreg: LSB-first shift register; serial bits enter at the MSB so the
// first bit received ends up in bit 0, and bit 0 is the next bit presented.
module spi_aes_shreg
  import spi_aes_pkg::*;
#(
  parameter int W = AES_BLOCK_W
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_par,
  input  logic         i_shift,
  input  logic         i_bit,
  output logic [W-1:0] o_par
);

  logic [W-1:0] r_q;

  // Clear beats load, load beats shift.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_q <= '0;
    end else if (i_clear) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_par;
    end else if (i_shift) begin
      r_q <= {i_bit, r_q[W-1:1]};
    end else begin
      r_q <= r_q;
    end
  end

  assign o_par = r_q;

endmodule

// File: rtl/spi_aes_frame.sv
// spi_aes_frame: serial block/key capture, start/done handshake to a parallel
// AES core, serial result readout. Define SPI_AES_FRAME_TIMEOUT_EN for the
// WAIT_CORE watchdog and its sticky o_err output.
module spi_aes_frame
  import spi_aes_pkg::*;
#(
  parameter int KEY_W       = 128,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_chip,
  input  logic                   i_enable,
  input  logic                   i_mode,
  input  logic                   i_in,
  output logic                   o_out,
  output logic                   o_out_valid,
  output logic                   o_busy,
  output logic                   o_core_start,
  output logic                   o_core_decrypt,
  output logic [AES_BLOCK_W-1:0] o_core_data,
  output logic [KEY_W-1:0]       o_core_key,
  input  logic                   i_core_done,
  input  logic [AES_BLOCK_W-1:0] i_core_result
`ifdef SPI_AES_FRAME_TIMEOUT_EN
  ,
  output logic                   o_err
`endif
);

  if (!key_w_legal(KEY_W)) begin : g_bad_key_w
    $error("spi_aes_frame: KEY_W must be 128, 192 or 256");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("spi_aes_frame: TIMEOUT_CYC must be at least 1");
  end

  localparam int CNT_W = $clog2(KEY_W);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(AES_BLOCK_W - 1);
  localparam logic [CNT_W-1:0] KEY_LAST  = CNT_W'(KEY_W - 1);

  state_e                 r_state, w_state_next;
  logic [CNT_W-1:0]       r_cnt, w_cnt_next;
  logic                   r_decrypt, w_decrypt_next;
  logic                   r_busy, r_start, r_out_valid;
  logic                   w_shift_cyc, w_timeout;
  logic                   w_shift_data, w_shift_key, w_shift_res;
  logic                   w_load_res, w_clear_res;
  logic [AES_BLOCK_W-1:0] w_res_par;

  assign w_shift_cyc = !i_chip && i_enable;

  // Next-state and datapath strobes; block and key phases share one counter.
  always_comb begin
    w_state_next   = r_state;
    w_cnt_next     = r_cnt;
    w_decrypt_next = r_decrypt;
    w_shift_data   = 1'b0;
    w_shift_key    = 1'b0;
    w_shift_res    = 1'b0;
    w_load_res     = 1'b0;
    w_clear_res    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_shift_cyc) begin
          w_shift_data   = 1'b1;
          w_decrypt_next = (i_mode == MODE_DEC);
          w_cnt_next     = CNT_W'(1);
          w_state_next   = LOAD_DATA;
        end else begin
          w_cnt_next = '0;
        end
      end
      LOAD_DATA: begin
        if (i_chip) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (i_enable) begin
          w_shift_data = 1'b1;
          if (r_cnt == DATA_LAST) begin
            w_cnt_next   = '0;
            w_state_next = LOAD_KEY;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      LOAD_KEY: begin
        if (i_chip) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (i_enable) begin
          w_shift_key = 1'b1;
          if (r_cnt == KEY_LAST) begin
            w_cnt_next   = '0;
            w_state_next = START;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      START: begin
        w_state_next = WAIT_CORE;
      end
      WAIT_CORE: begin
        if (i_core_done) begin
          w_load_res   = 1'b1;
          w_cnt_next   = '0;
          w_state_next = SHIFT_OUT;
        end else if (w_timeout) begin
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else begin
          w_state_next = WAIT_CORE;
        end
      end
      SHIFT_OUT: begin
        if (i_chip) begin
          w_clear_res  = 1'b1;
          w_cnt_next   = '0;
          w_state_next = IDLE;
        end else if (i_enable) begin
          w_shift_res = 1'b1;
          if (r_cnt == DATA_LAST) begin
            w_cnt_next   = '0;
            w_state_next = IDLE;
          end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
          end
        end else begin
          w_cnt_next = r_cnt;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  // State, counter and status flags, registered from the next state.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_decrypt   <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_decrypt   <= w_decrypt_next;
      r_busy      <= (w_state_next != IDLE);
      r_start     <= (w_state_next == START);
      r_out_valid <= (w_state_next == SHIFT_OUT);
    end
  end

`ifdef SPI_AES_FRAME_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] r_wd;
  logic            r_err;

  // Watchdog runs only while waiting; err is sticky until the next frame begins.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wd  <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == WAIT_CORE) && !i_core_done) begin
        r_wd <= r_wd + WD_W'(1);
      end else begin
        r_wd <= '0;
      end
      if ((r_state == WAIT_CORE) && !i_core_done && w_timeout) begin
        r_err <= 1'b1;
      end else if ((r_state == IDLE) && w_shift_cyc) begin
        r_err <= 1'b0;
      end else begin
        r_err <= r_err;
      end
    end
  end

  assign w_timeout = (r_wd == WD_LAST);
  assign o_err     = r_err;
`else
  assign w_timeout = 1'b0;
`endif

  spi_aes_shreg #(.W(AES_BLOCK_W)) u_data (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (1'b0),
    .i_load  (1'b0),
    .i_par   ('0),
    .i_shift (w_shift_data),
    .i_bit   (i_in),
    .o_par   (o_core_data)
  );

  spi_aes_shreg #(.W(KEY_W)) u_key (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (1'b0),
    .i_load  (1'b0),
    .i_par   ('0),
    .i_shift (w_shift_key),
    .i_bit   (i_in),
    .o_par   (o_core_key)
  );

  // Zeros are shifted in behind the result so out returns to 0 after bit 127.
  spi_aes_shreg #(.W(AES_BLOCK_W)) u_res (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear_res),
    .i_load  (w_load_res),
    .i_par   (i_core_result),
    .i_shift (w_shift_res),
    .i_bit   (1'b0),
    .o_par   (w_res_par)
  );

  logic w_unused_res;
  assign w_unused_res = &{1'b0, w_res_par[AES_BLOCK_W-1:1]};

  assign o_out          = w_res_par[0];
  assign o_out_valid    = r_out_valid;
  assign o_busy         = r_busy;
  assign o_core_start   = r_start;
  assign o_core_decrypt = r_decrypt;

endmodule

// File: tb/tb_spi_aes_frame.sv
// tb_spi_aes_frame: one controller per key length, each with a known-answer
// behavioural AES core; results are scoreboarded against constants or a model.
module tb_spi_aes_frame;

  localparam int LAT = 6;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, in_bit, mode;
  logic [2:0] chip, hold;
  logic [2:0] out_v, val_v, busy_v, start_v, dec_v, done_v, data_ok, key_ok, zero_v;
`ifdef SPI_AES_FRAME_TIMEOUT_EN
  logic [2:0] err_v;
`endif
  logic [127:0] exp_data;
  logic [255:0] exp_key;
  logic [127:0] sb_q[$];
  int checks = 0;
  int errors = 0;
  int starts[3] = '{0, 0, 0};
  int dones[3]  = '{0, 0, 0};

  // Known-answer core; any other input gets a simple reversible mix.
  function automatic logic [127:0] core_model(input logic [127:0] d, input logic [255:0] key,
                                              input int kw, input logic dec);
    if (!dec && kw == 128 && d == PT && key[127:0] == K128) return CT128;
    if (!dec && kw == 192 && d == PT && key[191:0] == K192) return CT192;
    if (dec && kw == 256 && d == CT256 && key == K256) return PT;
    return d ^ key[127:0] ^ {128{dec}};
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int KW = 128 + 64 * k;
    logic [127:0]  core_data;
    logic [127:0]  core_result = '0;
    logic [KW-1:0] core_key;
    logic          core_done = 1'b0;
    logic          pend = 1'b0;
    int            cd = 0;

    spi_aes_frame #(.KEY_W(KW), .TIMEOUT_CYC(64)) u_dut (
      .i_clk          (clk),
      .i_reset        (reset),
      .i_chip         (chip[k]),
      .i_enable       (enable),
      .i_mode         (mode),
      .i_in           (in_bit),
      .o_out          (out_v[k]),
      .o_out_valid    (val_v[k]),
      .o_busy         (busy_v[k]),
      .o_core_start   (start_v[k]),
      .o_core_decrypt (dec_v[k]),
      .o_core_data    (core_data),
      .o_core_key     (core_key),
      .i_core_done    (core_done),
      .i_core_result  (core_result)
`ifdef SPI_AES_FRAME_TIMEOUT_EN
      ,
      .o_err          (err_v[k])
`endif
    );

    assign data_ok[k] = (core_data == exp_data);
    assign key_ok[k]  = (core_key == exp_key[KW-1:0]);
    assign zero_v[k]  = (core_data == '0) && (core_key == '0);
    assign done_v[k]  = core_done;

    always @(posedge clk) begin
      core_done <= 1'b0;
      if (start_v[k]) begin
        pend <= 1'b1;
        cd   <= LAT;
      end else if (pend && !hold[k]) begin
        if (cd > 1) begin
          cd <= cd - 1;
        end else begin
          pend        <= 1'b0;
          core_done   <= 1'b1;
          core_result <= core_model(core_data, 256'(core_key), KW, dec_v[k]);
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (start_v[k]) starts[k] <= starts[k] + 1;
      if (done_v[k])  dones[k]  <= dones[k] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input int k, input logic [127:0] d, input logic [255:0] key,
                            input logic md, input int kw, input logic push,
                            input logic [127:0] expv);
    exp_data = d;
    exp_key  = key;
    if (push) sb_q.push_back(expv);
    chip = 3'b111;
    chip[k] = 1'b0;
    mode = md;
    for (int i = 0; i < 128 + kw; i++) begin
      logic b;
      b = (i < 128) ? d[i] : key[i-128];
      if ($urandom_range(0, 9) == 0) begin
        enable = 1'b0;
        in_bit = ~b;
        tick();
      end
      enable = 1'b1;
      in_bit = b;
      tick();
      mode = ~md;
    end
    enable = 1'b0;
  endtask

  task automatic recv(input int k, input string tag);
    logic [127:0] got, expv;
    logic prev;
    int n, vbad, sbad;
    got = '0; n = 0; vbad = 0; sbad = 0;
    chip = 3'b111;
    chip[k] = 1'b0;
    enable = 1'b0;
    while (!val_v[k] && n < 300) begin
      tick();
      n++;
    end
    check({tag, "_valid_seen"}, 128'(val_v[k]), 128'd1);
    for (int i = 0; i < 128; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        prev = out_v[k];
        enable = 1'b0;
        tick();
        if (out_v[k] !== prev || !val_v[k]) sbad++;
      end
      if (!val_v[k]) vbad++;
      got[i] = out_v[k];
      enable = 1'b1;
      tick();
    end
    enable = 1'b0;
    check({tag, "_valid_128"}, 128'(vbad), 128'd0);
    check({tag, "_stall_hold"}, 128'(sbad), 128'd0);
    check({tag, "_end_idle"}, 128'({val_v[k], out_v[k], busy_v[k]}), 128'd0);
    if (sb_q.size() > 0) expv = sb_q.pop_front();
    else expv = ~got;
    check({tag, "_result"}, got, expv);
    chip = 3'b111;
  endtask

  task automatic run_frame(input int k, input logic [127:0] d, input logic [255:0] key,
                           input logic md, input int kw, input logic [127:0] expv,
                           input logic chip_wait, input string tag);
    int s0;
    s0 = starts[k];
    if (chip_wait) hold[k] = 1'b1;
    send_frame(k, d, key, md, kw, 1'b1, expv);
    check({tag, "_core_data"}, 128'(data_ok[k]), 128'd1);
    check({tag, "_core_key"}, 128'(key_ok[k]), 128'd1);
    check({tag, "_core_dec"}, 128'(dec_v[k]), 128'(md));
    if (chip_wait) begin
      chip[k] = 1'b1;
      repeat (12) tick();
      check({tag, "_chip_wait_busy"}, 128'(busy_v[k]), 128'd1);
      hold[k] = 1'b0;
    end
    recv(k, tag);
    check({tag, "_one_start"}, 128'(starts[k] - s0), 128'd1);
    check({tag, "_dec_kept"}, 128'(dec_v[k]), 128'(md));
  endtask

  initial begin
    logic [127:0] d, v;
    logic [255:0] key;
    int s0, d0, bad, n;
    reset = 1'b0; chip = 3'b111; enable = 1'b0; in_bit = 1'b0; mode = 1'b0; hold = 3'b000;
    tick();
    tick();
    check("rst_outs", 128'({out_v, val_v, busy_v, start_v, dec_v}), 128'd0);
    check("rst_regs", 128'(zero_v), 128'd7);
    reset = 1'b1;
    tick();

    run_frame(0, PT, 256'(K128), 1'b0, 128, CT128, 1'b0, "enc128");
    run_frame(1, PT, 256'(K192), 1'b0, 192, CT192, 1'b1, "enc192");
    run_frame(2, CT256, K256, 1'b1, 256, PT, 1'b0, "dec256");
    d = {$urandom, $urandom, $urandom, $urandom};
    key = {8{$urandom}};
    run_frame(0, d, key, 1'b1, 128, d ^ key[127:0] ^ {128{1'b1}}, 1'b0, "rnd128");

    // Abort after 60 block bits.
    v = PT;
    s0 = starts[0];
    chip = 3'b110;
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      in_bit = v[i];
      tick();
    end
    check("abort_busy_mid", 128'(busy_v[0]), 128'd1);
    chip = 3'b111;
    enable = 1'b0;
    tick();
    check("abort_busy", 128'(busy_v[0]), 128'd0);
    repeat (20) tick();
    check("abort_no_start", 128'(starts[0] - s0), 128'd0);
    run_frame(0, PT, 256'(K128), 1'b0, 128, CT128, 1'b0, "after_abort");

    // Reset while waiting on the core, then a late core_done.
    hold = 3'b010;
    send_frame(1, PT, 256'(K192), 1'b1, 192, 1'b0, 128'd0);
    repeat (4) tick();
    check("wait_busy", 128'(busy_v[1]), 128'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rstw_outs", 128'({out_v[1], val_v[1], busy_v[1], start_v[1], dec_v[1]}), 128'd0);
    check("rstw_regs", 128'(zero_v[1]), 128'd1);
    d0 = dones[1];
    hold = 3'b000;
    bad = 0;
    repeat (20) begin
      tick();
      if (val_v[1] || busy_v[1]) bad++;
    end
    check("late_done_seen", 128'(dones[1] - d0), 128'd1);
    check("late_done_ignored", 128'(bad), 128'd0);
    run_frame(1, PT, 256'(K192), 1'b0, 192, CT192, 1'b0, "after_rst");

`ifdef SPI_AES_FRAME_TIMEOUT_EN
    hold = 3'b001;
    send_frame(0, PT, 256'(K128), 1'b0, 128, 1'b0, 128'd0);
    n = 0;
    while (busy_v[0] && n < 200) begin
      tick();
      n++;
    end
    check("wd_cycles", 128'(n), 128'd65);
    check("wd_err", 128'(err_v[0]), 128'd1);
    hold = 3'b000;
    chip = 3'b111;
    repeat (10) tick();
    check("wd_err_sticky", 128'({err_v[0], val_v[0]}), 128'b10);
    send_frame(0, PT, 256'(K128), 1'b0, 128, 1'b1, CT128);
    check("wd_err_clear", 128'(err_v[0]), 128'd0);
    recv(0, "after_wd");
`else
    n = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
